neuron_mac_sequencer: RTL

Time-multiplexed neuron engine that computes one neuron output, bias + Σ x[i]·w[i], by driving a single shared `MultAdd` cell over N_INPUTS cycles. It accepts a stream of (activation, weight) pairs over a valid/ready handshake, accumulates in signed Q5.10, and presents the result on a valid/ready output port. It sits between the layer-level weight/activation fetch logic and the next layer's input buffer, so one multiplier serves a whole neuron instead of one per input.

---
 rtl/neuron_mac_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: one neuron output bias + sum(x[i]*w[i]) in signed Q5.10 on one shared MultAdd cell.
// Latency: N_INPUTS+1 cycles from accepted start to out_valid; each in_valid=0 stall cycle adds one.
// Backpressure: in_ready only in ACCUM; y_out held stable in DONE until out_ready. Optional macro: NEURON_RELU_EN.

// Shared multiply-accumulate cell: y_out = y_in + ((a_in*b) >>> FRAC_BITS), wrapped to 16 bits.
module MultAdd #(
  parameter int FRAC_BITS = 10
) (
  input  logic signed [15:0] a_in,
  input  logic signed [15:0] b,
  input  logic signed [15:0] y_in,
  output logic signed [15:0] y_out
);

  logic signed [31:0] prod;

  assign prod  = a_in * b;
  // Arithmetic shift floors toward -inf; the final cast keeps the low 16 bits (wrap, no saturation).
  assign y_out = 16'(y_in + (prod >>> FRAC_BITS));

endmodule

module neuron_mac_sequencer #(
  parameter int N_INPUTS  = 8,
  parameter int FRAC_BITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] w_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] y_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic signed [15:0] acc_q, acc_d;
  logic        [7:0]  cnt_q, cnt_d;
  logic signed [15:0] y_q, y_d;
  logic signed [15:0] mac_y;
  logic               last_pair;

  // Activation applied once, on the way into DONE.
  function automatic logic signed [15:0] activate(input logic signed [15:0] v);
`ifdef NEURON_RELU_EN
    return v[15] ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  MultAdd #(
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .a_in (x_in),
    .b    (w_in),
    .y_in (acc_q),
    .y_out(mac_y)
  );

  assign last_pair = (cnt_q == 8'(N_INPUTS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only honoured in IDLE, last accepted pair ends ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (in_valid && last_pair) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state alone, so no input-to-output combinational path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE:  busy      = 1'b0;
      S_ACCUM: in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Datapath next values: bias load on start, one MAC per accepted pair, result capture on the last pair.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    y_d   = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = bias;
          cnt_d = 8'd0;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = mac_y;
          cnt_d = cnt_q + 8'd1;
          if (last_pair) y_d = activate(mac_y);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
    end
  end

  assign y_out = y_q;

endmodule
